// File: rtl/multicycle_ctrl_v2.sv
// Control unit for the multicycle RV32I datapath: main FSM, ALU-control decode,
// memory ready/wait handshake, illegal-instruction trap and retired-instruction counter.
module multicycle_ctrl_v2 #(
   parameter bit          MEM_HANDSHAKE = 1'b1,
   parameter int unsigned CNT_W         = 32
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic [31:0]      i_instr,
   input  logic             i_alu_zero,
   input  logic             i_mem_ready,
   output logic             o_mem_read,
   output logic             o_mem_write,
   output logic             o_iord,
   output logic             o_ir_write,
   output logic             o_reg_write,
   output logic [1:0]       o_alu_src_a,
   output logic [1:0]       o_alu_src_b,
   output logic [3:0]       o_alu_ctrl,
   output logic [1:0]       o_mem_to_reg,
   output logic             o_pc_source,
   output logic             o_pc_en,
   output logic             o_trap,
   output logic [CNT_W-1:0] o_instret,
   output logic [3:0]       o_state_output
);

   typedef enum logic [3:0] {
      StFetch   = 4'd0,
      StDecode  = 4'd1,
      StMemAdr  = 4'd2,
      StMemRd   = 4'd3,
      StMemWb   = 4'd4,
      StMemWr   = 4'd5,
      StExecR   = 4'd6,
      StAluWb   = 4'd7,
      StBranch  = 4'd8,
      StExecI   = 4'd9,
      StJal     = 4'd10,
      StExecLui = 4'd11,
      StTrap    = 4'd12
   } state_e;

   localparam logic [6:0] OpLoad   = 7'h03;
   localparam logic [6:0] OpStore  = 7'h23;
   localparam logic [6:0] OpImm    = 7'h13;
   localparam logic [6:0] OpReg    = 7'h33;
   localparam logic [6:0] OpBranch = 7'h63;
   localparam logic [6:0] OpJal    = 7'h6f;
   localparam logic [6:0] OpLui    = 7'h37;

   localparam logic [3:0] AluAnd = 4'b0000;
   localparam logic [3:0] AluOr  = 4'b0001;
   localparam logic [3:0] AluAdd = 4'b0010;
   localparam logic [3:0] AluXor = 4'b0011;
   localparam logic [3:0] AluSll = 4'b0100;
   localparam logic [3:0] AluSrl = 4'b0101;
   localparam logic [3:0] AluSub = 4'b0110;
   localparam logic [3:0] AluSlt = 4'b0111;

   state_e           r_state;
   state_e           w_next;
   logic [CNT_W-1:0] r_instret;
   logic [6:0]       w_opcode;
   logic [2:0]       w_funct3;
   logic [6:0]       w_funct7;
   logic             w_mem_rdy;
   logic             w_retire;
   logic [3:0]       w_r_alu;
   logic             w_r_ok;
   logic [3:0]       w_i_alu;
   logic             w_i_ok;
   logic             w_br_ok;
   logic             w_unused_instr;

   assign w_opcode       = i_instr[6:0];
   assign w_funct3       = i_instr[14:12];
   assign w_funct7       = i_instr[31:25];
   assign w_unused_instr = ^{i_instr[24:15], i_instr[11:7]};
   assign w_mem_rdy      = MEM_HANDSHAKE ? i_mem_ready : 1'b1;
   assign w_br_ok        = (w_funct3 == 3'd0) || (w_funct3 == 3'd1);

   always_comb begin
      w_r_ok  = 1'b1;
      w_r_alu = AluAdd;
      case ({w_funct7, w_funct3})
         {7'h00, 3'd0}: w_r_alu = AluAdd;
         {7'h20, 3'd0}: w_r_alu = AluSub;
         {7'h00, 3'd7}: w_r_alu = AluAnd;
         {7'h00, 3'd6}: w_r_alu = AluOr;
         {7'h00, 3'd4}: w_r_alu = AluXor;
         {7'h00, 3'd1}: w_r_alu = AluSll;
         {7'h00, 3'd5}: w_r_alu = AluSrl;
         {7'h00, 3'd2}: w_r_alu = AluSlt;
         default:       w_r_ok  = 1'b0;
      endcase
   end

   always_comb begin
      w_i_ok  = 1'b1;
      w_i_alu = AluAdd;
      case (w_funct3)
         3'd0:    w_i_alu = AluAdd;
         3'd7:    w_i_alu = AluAnd;
         3'd6:    w_i_alu = AluOr;
         default: w_i_ok  = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state   <= StFetch;
         r_instret <= '0;
      end else begin
         r_state <= w_next;
         if (w_retire) begin
            r_instret <= r_instret + CNT_W'(1);
         end
      end
   end

   always_comb begin
      w_next = r_state;
      case (r_state)
         StFetch:   if (w_mem_rdy) w_next = StDecode;
         StDecode: begin
            case (w_opcode)
               OpLoad, OpStore: w_next = StMemAdr;
               OpImm:           w_next = w_i_ok ? StExecI : StTrap;
               OpReg:           w_next = w_r_ok ? StExecR : StTrap;
               OpBranch:        w_next = w_br_ok ? StBranch : StTrap;
               OpJal:           w_next = StJal;
               OpLui:           w_next = StExecLui;
               default:         w_next = StTrap;
            endcase
         end
         StMemAdr:  w_next = (w_opcode == OpStore) ? StMemWr : StMemRd;
         StMemRd:   if (w_mem_rdy) w_next = StMemWb;
         StMemWb:   w_next = StFetch;
         StMemWr:   if (w_mem_rdy) w_next = StFetch;
         StExecR:   w_next = StAluWb;
         StAluWb:   w_next = StFetch;
         StBranch:  w_next = StFetch;
         StExecI:   w_next = StAluWb;
         StJal:     w_next = StFetch;
         StExecLui: w_next = StAluWb;
         StTrap:    w_next = StTrap;
         default:   w_next = StFetch;
      endcase
   end

   // Only completing states retire; a wait in MEMWR keeps w_next off FETCH.
   assign w_retire = (w_next == StFetch) &&
                     ((r_state == StMemWb) || (r_state == StMemWr) || (r_state == StAluWb) ||
                      (r_state == StBranch) || (r_state == StJal));

   always_comb begin
      o_mem_read   = 1'b0;
      o_mem_write  = 1'b0;
      o_iord       = 1'b0;
      o_ir_write   = 1'b0;
      o_reg_write  = 1'b0;
      o_alu_src_a  = 2'd0;
      o_alu_src_b  = 2'd0;
      o_alu_ctrl   = AluAdd;
      o_mem_to_reg = 2'd0;
      o_pc_source  = 1'b0;
      o_pc_en      = 1'b0;
      o_trap       = 1'b0;
      case (r_state)
         StFetch: begin
            o_mem_read  = 1'b1;
            o_alu_src_b = 2'd1;
            o_ir_write  = w_mem_rdy & i_reset_n;
            o_pc_en     = w_mem_rdy & i_reset_n;
         end
         StDecode:  o_alu_src_b = 2'd2;
         StMemAdr: begin
            o_alu_src_a = 2'd1;
            o_alu_src_b = 2'd2;
         end
         StMemRd: begin
            o_mem_read = 1'b1;
            o_iord     = 1'b1;
         end
         StMemWb: begin
            o_reg_write  = 1'b1;
            o_mem_to_reg = 2'd1;
         end
         StMemWr: begin
            o_mem_write = 1'b1;
            o_iord      = 1'b1;
         end
         StExecR: begin
            o_alu_src_a = 2'd1;
            o_alu_ctrl  = w_r_alu;
         end
         StAluWb:   o_reg_write = 1'b1;
         StBranch: begin
            o_alu_src_a = 2'd1;
            o_alu_ctrl  = AluSub;
            o_pc_source = 1'b1;
            o_pc_en     = w_funct3[0] ? ~i_alu_zero : i_alu_zero;
         end
         StExecI: begin
            o_alu_src_a = 2'd1;
            o_alu_src_b = 2'd2;
            o_alu_ctrl  = w_i_alu;
         end
         StJal: begin
            o_reg_write  = 1'b1;
            o_mem_to_reg = 2'd2;
            o_pc_source  = 1'b1;
            o_pc_en      = 1'b1;
         end
         StExecLui: begin
            o_alu_src_a = 2'd2;
            o_alu_src_b = 2'd2;
         end
         StTrap:    o_trap = 1'b1;
         default:   ;
      endcase
   end

   assign o_instret      = r_instret;
   assign o_state_output = r_state;

endmodule

// File: tb/tb_multicycle_ctrl_v2.sv
// Bench for multicycle_ctrl_v2: directed and random instructions checked against a
// per-instruction state-sequence model and the per-state output table.
module tb_multicycle_ctrl_v2;

   localparam int K_LW = 0, K_SW = 1, K_R = 2, K_I = 3, K_BEQ = 4, K_BNE = 5;
   localparam int K_JAL = 6, K_LUI = 7, K_ILL = 8;

   typedef struct packed {
      logic       mem_read;
      logic       mem_write;
      logic       iord;
      logic       ir_write;
      logic       reg_write;
      logic [1:0] a;
      logic [1:0] b;
      logic [3:0] alu;
      logic [1:0] m2r;
      logic       pc_source;
      logic       pc_en;
      logic       trap;
   } out_t;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [31:0] instr;
   logic        alu_zero;
   logic        mem_ready;
   logic        mem_read, mem_write, iord, ir_write, reg_write, pc_source, pc_en, trap;
   logic [1:0]  alu_src_a, alu_src_b, mem_to_reg;
   logic [3:0]  alu_ctrl, state;
   logic [31:0] instret;

   logic [31:0] instr2 = 32'h00402083;
   logic        nh_mem_read, nh_mem_write, nh_iord, nh_ir_write, nh_reg_write;
   logic        nh_pc_source, nh_pc_en, nh_trap;
   logic [1:0]  nh_alu_src_a, nh_alu_src_b, nh_mem_to_reg;
   logic [3:0]  nh_alu_ctrl, nh_state;
   logic [7:0]  nh_instret;

   out_t act;
   int   checks = 0;
   int   errors = 0;
   int   exp_instret = 0;

   bit [6:0] r_f7  [8] = '{7'h00, 7'h20, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};
   bit [2:0] r_f3  [8] = '{3'd0, 3'd0, 3'd7, 3'd6, 3'd4, 3'd1, 3'd5, 3'd2};
   bit [3:0] r_alu [8] = '{4'd2, 4'd6, 4'd0, 4'd1, 4'd3, 4'd4, 4'd5, 4'd7};
   int       nh_seq [6] = '{0, 1, 2, 3, 4, 0};

   always #5 clk = ~clk;

   assign act = {mem_read, mem_write, iord, ir_write, reg_write, alu_src_a, alu_src_b,
                 alu_ctrl, mem_to_reg, pc_source, pc_en, trap};

   multicycle_ctrl_v2 #(.MEM_HANDSHAKE(1'b1), .CNT_W(32)) u_dut (
      .i_clk(clk), .i_reset_n(reset_n), .i_instr(instr), .i_alu_zero(alu_zero),
      .i_mem_ready(mem_ready), .o_mem_read(mem_read), .o_mem_write(mem_write),
      .o_iord(iord), .o_ir_write(ir_write), .o_reg_write(reg_write),
      .o_alu_src_a(alu_src_a), .o_alu_src_b(alu_src_b), .o_alu_ctrl(alu_ctrl),
      .o_mem_to_reg(mem_to_reg), .o_pc_source(pc_source), .o_pc_en(pc_en), .o_trap(trap),
      .o_instret(instret), .o_state_output(state)
   );

   multicycle_ctrl_v2 #(.MEM_HANDSHAKE(1'b0), .CNT_W(8)) u_dut_nh (
      .i_clk(clk), .i_reset_n(reset_n), .i_instr(instr2), .i_alu_zero(1'b0),
      .i_mem_ready(1'b0), .o_mem_read(nh_mem_read), .o_mem_write(nh_mem_write),
      .o_iord(nh_iord), .o_ir_write(nh_ir_write), .o_reg_write(nh_reg_write),
      .o_alu_src_a(nh_alu_src_a), .o_alu_src_b(nh_alu_src_b), .o_alu_ctrl(nh_alu_ctrl),
      .o_mem_to_reg(nh_mem_to_reg), .o_pc_source(nh_pc_source), .o_pc_en(nh_pc_en),
      .o_trap(nh_trap), .o_instret(nh_instret), .o_state_output(nh_state)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Output table: what each state drives for the given instruction and inputs.
   function automatic out_t exp_out(input int st, input logic [31:0] ins, input bit z,
                                    input bit rdy, input bit rst);
      out_t e;
      e     = '0;
      e.alu = 4'd2;
      case (st)
         0: begin
            e.mem_read = 1'b1;
            e.b        = 2'd1;
            e.ir_write = rdy & rst;
            e.pc_en    = rdy & rst;
         end
         1: e.b = 2'd2;
         2: begin e.a = 2'd1; e.b = 2'd2; end
         3: begin e.mem_read = 1'b1; e.iord = 1'b1; end
         4: begin e.reg_write = 1'b1; e.m2r = 2'd1; end
         5: begin e.mem_write = 1'b1; e.iord = 1'b1; end
         6: begin
            e.a = 2'd1;
            for (int i = 0; i < 8; i++)
               if (ins[31:25] == r_f7[i] && ins[14:12] == r_f3[i]) e.alu = r_alu[i];
         end
         7: e.reg_write = 1'b1;
         8: begin
            e.a         = 2'd1;
            e.alu       = 4'd6;
            e.pc_source = 1'b1;
            e.pc_en     = (ins[14:12] == 3'd0) ? z : !z;
         end
         9: begin
            e.a   = 2'd1;
            e.b   = 2'd2;
            e.alu = (ins[14:12] == 3'd0) ? 4'd2 : (ins[14:12] == 3'd7) ? 4'd0 : 4'd1;
         end
         10: begin e.reg_write = 1'b1; e.m2r = 2'd2; e.pc_source = 1'b1; e.pc_en = 1'b1; end
         11: begin e.a = 2'd2; e.b = 2'd2; end
         12: e.trap = 1'b1;
         default: ;
      endcase
      return e;
   endfunction

   task automatic gen(input int k, output logic [31:0] ins);
      int p;
      ins = $urandom;
      case (k)
         K_LW:  begin ins[6:0] = 7'h03; ins[14:12] = 3'd2; end
         K_SW:  begin ins[6:0] = 7'h23; ins[14:12] = 3'd2; end
         K_R: begin
            p = $urandom_range(0, 7);
            ins[6:0] = 7'h33; ins[31:25] = r_f7[p]; ins[14:12] = r_f3[p];
         end
         K_I: begin
            p = $urandom_range(0, 2);
            ins[6:0]   = 7'h13;
            ins[14:12] = (p == 0) ? 3'd0 : (p == 1) ? 3'd7 : 3'd6;
         end
         K_BEQ: begin ins[6:0] = 7'h63; ins[14:12] = 3'd0; end
         K_BNE: begin ins[6:0] = 7'h63; ins[14:12] = 3'd1; end
         K_JAL: ins[6:0] = 7'h6f;
         K_LUI: ins[6:0] = 7'h37;
         default: begin
            p = $urandom_range(0, 3);
            case (p)
               0:       ins[6:0] = 7'h7f;
               1:       begin ins[6:0] = 7'h33; ins[31:25] = 7'h01; end
               2:       begin ins[6:0] = 7'h13; ins[14:12] = 3'd1; end
               default: begin ins[6:0] = 7'h63; ins[14:12] = 3'd4; end
            endcase
         end
      endcase
   endtask

   task automatic step_check(input int st, input logic [31:0] ins, input bit z, input bit rdy);
      @(negedge clk);
      instr     = ins;
      alu_zero  = z;
      mem_ready = rdy;
      #1;
      chk("state", 64'(state), 64'(st));
      chk("outs", 64'(act), 64'(exp_out(st, ins, z, rdy, 1'b1)));
   endtask

   // wf = FETCH wait cycles; wm = memory wait cycles, or TRAP dwell for illegal ops.
   task automatic run_instr(input int k, input logic [31:0] ins, input bit z, input int wf,
                            input int wm);
      int sq[$];
      bit rq[$];
      for (int i = 0; i < wf; i++) begin sq.push_back(0); rq.push_back(1'b0); end
      sq.push_back(0); rq.push_back(1'b1);
      sq.push_back(1); rq.push_back(1'($urandom));
      case (k)
         K_LW: begin
            sq.push_back(2); rq.push_back(1'($urandom));
            for (int i = 0; i < wm; i++) begin sq.push_back(3); rq.push_back(1'b0); end
            sq.push_back(3); rq.push_back(1'b1);
            sq.push_back(4); rq.push_back(1'($urandom));
         end
         K_SW: begin
            sq.push_back(2); rq.push_back(1'($urandom));
            for (int i = 0; i < wm; i++) begin sq.push_back(5); rq.push_back(1'b0); end
            sq.push_back(5); rq.push_back(1'b1);
         end
         K_R:   begin sq.push_back(6);  sq.push_back(7); rq.push_back(1'b1); rq.push_back(1'b0); end
         K_I:   begin sq.push_back(9);  sq.push_back(7); rq.push_back(1'b0); rq.push_back(1'b1); end
         K_LUI: begin sq.push_back(11); sq.push_back(7); rq.push_back(1'b1); rq.push_back(1'b1); end
         K_BEQ, K_BNE: begin sq.push_back(8); rq.push_back(1'($urandom)); end
         K_JAL: begin sq.push_back(10); rq.push_back(1'($urandom)); end
         default:
            for (int i = 0; i < wm; i++) begin sq.push_back(12); rq.push_back(1'($urandom)); end
      endcase
      for (int i = 0; i < sq.size(); i++) begin
         step_check(sq[i], ins, z, rq[i]);
         if (i == 0) chk("instret", 64'(instret), 64'(exp_instret));
      end
      if (k != K_ILL) exp_instret++;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3;
      mem_ready = 1'b1;
      reset_n   = 1'b0;
      #1;
      exp_instret = 0;
      chk("rst_state", 64'(state), 64'd0);
      chk("rst_trap", 64'(trap), 64'd0);
      chk("rst_instret", 64'(instret), 64'd0);
      chk("rst_outs", 64'(act), 64'(exp_out(0, instr, alu_zero, 1'b1, 1'b0)));
      mem_ready = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
   endtask

   initial begin
      logic [31:0] ins;
      int          k;
      reset_n   = 1'b1;
      instr     = 32'h0;
      alu_zero  = 1'b0;
      mem_ready = 1'b1;
      #2 reset_n = 1'b0;
      #1;
      chk("init_state", 64'(state), 64'd0);
      chk("init_instret", 64'(instret), 64'd0);
      chk("init_outs", 64'(act), 64'(exp_out(0, instr, 1'b0, 1'b1, 1'b0)));
      mem_ready = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;

      // No-handshake instance: LW completes in 5 cycles with mem_ready tied low.
      #1;
      chk("nh_state", 64'(nh_state), 64'd0);
      chk("nh_ir_write", 64'(nh_ir_write), 64'd1);
      for (int c = 1; c < 6; c++) begin
         @(negedge clk);
         #1;
         chk("nh_state", 64'(nh_state), 64'(nh_seq[c]));
         if (c == 3) chk("nh_mem_read", 64'(nh_mem_read), 64'd1);
      end
      chk("nh_instret", 64'(nh_instret), 64'd1);

      run_instr(K_LW,  32'h00402083, 1'b0, 0, 0);
      run_instr(K_SW,  32'h00102423, 1'b0, 0, 3);
      run_instr(K_R,   32'h403100B3, 1'b0, 1, 0);
      run_instr(K_R,   32'h003120B3, 1'b1, 0, 0);
      run_instr(K_BNE, 32'h00209463, 1'b0, 0, 0);
      run_instr(K_BEQ, 32'h00208463, 1'b0, 2, 0);
      run_instr(K_JAL, 32'h010000EF, 1'b0, 0, 0);
      run_instr(K_LUI, 32'h123450B7, 1'b0, 0, 0);
      run_instr(K_ILL, 32'h0000007F, 1'b0, 0, 20);
      do_reset();

      for (int n = 0; n < 40; n++) begin
         k = $urandom_range(0, 8);
         gen(k, ins);
         run_instr(k, ins, 1'($urandom), $urandom_range(0, 2),
                   (k == K_ILL) ? 3 : $urandom_range(0, 3));
         if (k == K_ILL) do_reset();
      end
      @(negedge clk);
      #1;
      chk("final_instret", 64'(instret), 64'(exp_instret));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/multicycle_ctrl_v2.md
# multicycle_ctrl_v2

Second-generation control unit for the multicycle RV32I datapath. It merges the main control state machine and ALU-control decode into one block and adds:
- BNE, JAL, LUI, ANDI, ORI and the XOR/SLL/SRL/SLT R-type ops;
- a ready/wait memory handshake for variable-latency memory;
- an illegal-instruction trap;
- a retired-instruction counter.

It drives every mux and enable of the shared-memory datapath from the instruction register and ALU zero flag.

## Interface
Parameters:
- MEM_HANDSHAKE, 1: 1 = memory states wait for mem_ready; 0 = mem_ready ignored, treated as 1.
- CNT_W, 32: width of instret counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset_n  in  1  reset, asynchronous, active-low.
- instr  in  32  IR contents; opcode=[6:0], funct3=[14:12], funct7=[31:25].
- alu_zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes current read/write this cycle.
- mem_read, mem_write  out  1  memory strobes.
- iord  out  1  0=PC address, 1=ALUOut address.
- ir_write  out  1  load IR.
- reg_write  out  1  register-file write.
- alu_src_a  out  2  0=PC, 1=A, 2=zero.
- alu_src_b  out  2  0=B, 1=constant 4, 2=imm.
- alu_ctrl  out  4  AND 0000, OR 0001, ADD 0010, XOR 0011, SLL 0100, SRL 0101, SUB 0110, SLT 0111.
- mem_to_reg  out  2  0=ALUOut, 1=MDR, 2=PC.
- pc_source  out  1  0=ALU result, 1=ALUOut.
- pc_en  out  1  final PC write enable.
- trap  out  1  illegal instruction seen; sticky.
- instret  out  CNT_W  retired-instruction count.
- state_output  out  4  current state encoding.

## Operation
States, with encodings:
- FETCH=0: mem_read, iord=0, A=PC, B=4, ADD, pc_source=0.
  - ir_write and pc_en are asserted only in the cycle where mem_ready=1.
  - Stay in FETCH until then.
- DECODE=1: A=PC, B=imm, ADD; the branch/JAL target is latched into ALUOut by the datapath.
  - LW/SW → MEMADR; ADDI/ANDI/ORI → EXEC_I; R-type → EXEC_R; BEQ/BNE → BRANCH; JAL → JAL; LUI → EXEC_LUI.
  - Any other opcode → TRAP.
  - R-type with an unsupported funct7/funct3 pair → TRAP.
- MEMADR=2: A=A, B=imm, ADD. LW → MEMRD, SW → MEMWR.
- MEMRD=3: mem_read, iord=1. Wait for mem_ready, then → MEMWB.
- MEMWB=4: reg_write, mem_to_reg=1 → FETCH.
- MEMWR=5: mem_write, iord=1. Wait for mem_ready, then → FETCH.
- EXEC_R=6: A=A, B=B, alu_ctrl from the funct fields → ALUWB.
  - Supported pairs (funct7, funct3): (00,0) ADD, (20,0) SUB, (00,7) AND, (00,6) OR, (00,4) XOR, (00,1) SLL, (00,5) SRL, (00,2) SLT.
- ALUWB=7: reg_write, mem_to_reg=0 → FETCH.
- BRANCH=8: A=A, B=B, SUB, pc_source=1 → FETCH.
  - pc_en = alu_zero for BEQ (funct3=0), !alu_zero for BNE (funct3=1).
  - Any other funct3 in DECODE → TRAP.
- EXEC_I=9: A=A, B=imm → ALUWB.
  - ADD for funct3=0, AND for 7, OR for 6; any other funct3 → TRAP (checked in DECODE).
- JAL=10: reg_write, mem_to_reg=2 (PC already holds old PC+4), pc_source=1, pc_en=1 → FETCH.
- EXEC_LUI=11: A=zero, B=imm, ADD → ALUWB.
- TRAP=12: all strobes/enables 0, trap=1. Exit only via reset.

Outputs not listed for a state:
- mem_read, mem_write, ir_write, reg_write, pc_en are 0.
- Muxes and alu_ctrl are 0, except alu_ctrl=ADD.

Other rules:
- Encodings 13–15 → FETCH next cycle, all enables 0.
- instret += 1 (wraps modulo 2^CNT_W) on every transition into FETCH from MEMWB, MEMWR, ALUWB, BRANCH or JAL.
- With MEM_HANDSHAKE=0, every memory state lasts exactly one cycle.

## Timing
- All outputs are combinational functions of registered state, plus instr/alu_zero/mem_ready where stated.
- Latency with zero wait states: LW 5 cycles; SW, R-type, I-type, LUI 4 cycles; BEQ/BNE and JAL 3 cycles. Each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds 1 cycle.
- mem_read/mem_write stay asserted and iord stays stable for the whole wait.
- Reset asserted: state=FETCH, trap=0, instret=0 immediately, regardless of clk. Mid-instruction reset abandons the instruction without counting it.
- Outputs in reset, under FETCH decode:
  - mem_read=1, iord=0, alu_src_a=0, alu_src_b=1, alu_ctrl=ADD, pc_source=0.
  - ir_write=pc_en=0 while reset_n=0.
  - All other outputs 0.
- Reset deasserts → first edge evaluates FETCH.

## Test plan
- Reset + LW x1,4(x0), mem_ready held 1 → states 0,1,2,3,4,0; reg_write only in state 4 with mem_to_reg=1; instret=1.
- SW with mem_ready low 3 cycles in MEMWR → mem_write/iord=1 for 4 cycles; state stays 5; 7 total cycles; instret increments once.
- SUB then SLT R-type (funct7=0x20/f3=0, funct7=0/f3=2) → alu_ctrl 0110 then 0111 in state 6; BNE with alu_zero=0 → pc_en=1 in state 8; BEQ with alu_zero=0 → pc_en=0.
- JAL → state 10 with reg_write=1, mem_to_reg=2, pc_en=1; LUI → state 11 with alu_src_a=2, alu_src_b=2, then state 7 write.
- Opcode 7'b1111111 → TRAP in cycle 3, trap=1 and all enables 0 for 20 cycles; reset_n pulsed low mid-cycle → state 0, trap=0, instret=0 without a clock edge.
- MEM_HANDSHAKE=0 with mem_ready tied 0 → LW still completes in 5 cycles.
